// File: rtl/tank_pkg.sv
// tank_pkg: shared types and geometry for the player tank damage logic.
// Optional feature macro used by tank_damage: TANK_INVULN_EN.
package tank_pkg;

  // ST_GUARD is only reachable when TANK_INVULN_EN is defined.
  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_BOOM      = 2'd1,
    ST_GUARD     = 2'd2,
    ST_GAME_OVER = 2'd3
  } tank_state_t;

  localparam int TANK_SIZE   = 32;
  localparam int BULLET_SIZE = 4;
  localparam int X_MAX       = 639;
  localparam int Y_MAX       = 479;

endpackage

// File: rtl/tank_bullet_overlap.sv
// tank_bullet_overlap: combinational box test of one 4x4 bullet against
// the 32x32 tank. Right/bottom edges are formed at 11 bits so positions
// near X_MAX/Y_MAX cannot wrap.
module tank_bullet_overlap
  import tank_pkg::*;
(
  input  logic [9:0] i_x_tank,
  input  logic [9:0] i_y_tank,
  input  logic [9:0] i_x_bullet,
  input  logic [9:0] i_y_bullet,
  output logic       o_overlap
);

  logic [10:0] w_xt;
  logic [10:0] w_yt;
  logic [10:0] w_xb;
  logic [10:0] w_yb;
  logic [10:0] w_xt_end;
  logic [10:0] w_yt_end;
  logic [10:0] w_xb_end;
  logic [10:0] w_yb_end;

  assign w_xt     = {1'b0, i_x_tank};
  assign w_yt     = {1'b0, i_y_tank};
  assign w_xb     = {1'b0, i_x_bullet};
  assign w_yb     = {1'b0, i_y_bullet};
  assign w_xt_end = w_xt + 11'(TANK_SIZE);
  assign w_yt_end = w_yt + 11'(TANK_SIZE);
  assign w_xb_end = w_xb + 11'(BULLET_SIZE);
  assign w_yb_end = w_yb + 11'(BULLET_SIZE);

  assign o_overlap = (w_xb < w_xt_end) && (w_xb_end > w_xt) &&
                     (w_yb < w_yt_end) && (w_yb_end > w_yt);

endmodule

// File: rtl/tank_damage.sv
// tank_damage: player-side hit responder. Checks every enemy bullet on each
// refresh_tick, retires overlapping bullets, and runs the explosion / lives /
// respawn / game-over sequence. Everything advances on refresh_tick only,
// except respawn, which is a single clk_50MHz pulse.
// Optional feature macro: TANK_INVULN_EN (post-respawn GUARD window).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_ALIVE     | tank vulnerable; any overlap costs a life and starts BOOM
// ST_BOOM      | explosion running, boom_frame counts 0..BOOM_FRAMES-1
// ST_GUARD     | post-respawn grace: bullets absorbed, no life lost
// ST_GAME_OVER | lives exhausted; held until reset
module tank_damage
  import tank_pkg::*;
#(
  parameter int NUM_ENEMIES   = 3,
  parameter int LIVES         = 3,
  parameter int BOOM_FRAMES   = 8
`ifdef TANK_INVULN_EN
  , parameter int INVULN_FRAMES = 64
`endif
) (
  input  logic                      clk_50MHz,
  input  logic                      reset,
  input  logic                      refresh_tick,
  input  logic [9:0]                x_tank,
  input  logic [9:0]                y_tank,
  input  logic [10*NUM_ENEMIES-1:0] x_bullet_e,
  input  logic [10*NUM_ENEMIES-1:0] y_bullet_e,
  output logic [NUM_ENEMIES-1:0]    hit,
  output logic                      tank_detroyed,
  output logic [2:0]                boom_frame,
  output logic [1:0]                lives,
  output logic                      respawn,
  output logic                      game_over
);

  localparam logic [2:0] FRAME_LAST = 3'(BOOM_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  logic [NUM_ENEMIES-1:0] w_overlap;
  tank_state_t            r_state;
  logic [NUM_ENEMIES-1:0] r_hit;
  logic                   r_destroyed;
  logic [2:0]             r_boom_frame;
  logic [1:0]             r_lives;
  logic                   r_respawn;
  logic                   r_game_over;

`ifdef TANK_INVULN_EN
  localparam int GUARD_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(INVULN_FRAMES - 1);
  logic [GUARD_W-1:0] r_guard_cnt;
`endif

  for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_overlap
    tank_bullet_overlap u_overlap (
      .i_x_tank   (x_tank),
      .i_y_tank   (y_tank),
      .i_x_bullet (x_bullet_e[10*gi +: 10]),
      .i_y_bullet (y_bullet_e[10*gi +: 10]),
      .o_overlap  (w_overlap[gi])
    );
  end

  // Damage FSM and registered outputs, advanced once per refresh_tick.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state      <= ST_ALIVE;
      r_hit        <= '0;
      r_destroyed  <= 1'b0;
      r_boom_frame <= 3'd0;
      r_lives      <= LIVES_INIT;
      r_respawn    <= 1'b0;
      r_game_over  <= 1'b0;
`ifdef TANK_INVULN_EN
      r_guard_cnt  <= '0;
`endif
    end else begin
      r_respawn <= 1'b0;
      if (refresh_tick) begin
        case (r_state)
          ST_ALIVE: begin
            if (|w_overlap) begin
              r_hit        <= w_overlap;
              r_state      <= ST_BOOM;
              r_lives      <= r_lives - 2'd1;
              r_boom_frame <= 3'd0;
              r_destroyed  <= 1'b1;
            end else begin
              r_hit <= '0;
            end
          end
          ST_BOOM: begin
            r_hit <= '0;
            if (r_boom_frame == FRAME_LAST) begin
              if (r_lives == 2'd0) begin
                r_state     <= ST_GAME_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_respawn    <= 1'b1;
                r_boom_frame <= 3'd0;
                r_destroyed  <= 1'b0;
`ifdef TANK_INVULN_EN
                r_state      <= ST_GUARD;
                r_guard_cnt  <= GUARD_LOAD;
`else
                r_state      <= ST_ALIVE;
`endif
              end
            end else begin
              r_boom_frame <= r_boom_frame + 3'd1;
            end
          end
`ifdef TANK_INVULN_EN
          ST_GUARD: begin
            // Bullets are absorbed here: they retire but cost nothing.
            r_hit <= w_overlap;
            if (r_guard_cnt == '0) begin
              r_state <= ST_ALIVE;
            end else begin
              r_guard_cnt <= r_guard_cnt - 1'b1;
            end
          end
`endif
          ST_GAME_OVER: begin
            r_hit        <= '0;
            r_destroyed  <= 1'b1;
            r_boom_frame <= FRAME_LAST;
            r_lives      <= 2'd0;
            r_game_over  <= 1'b1;
          end
          default: begin
            r_state <= ST_ALIVE;
            r_hit   <= '0;
          end
        endcase
      end
    end
  end

  assign hit           = r_hit;
  assign tank_detroyed = r_destroyed;
  assign boom_frame    = r_boom_frame;
  assign lives         = r_lives;
  assign respawn       = r_respawn;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_tank_damage.sv
// tb_tank_damage: directed scenarios followed by randomized bullet traffic,
// every cycle compared against a tick-level behavioural model of the
// player's life cycle.
module tb_tank_damage;

  localparam int NE  = 3;
  localparam int LV  = 3;
  localparam int BF  = 8;
  localparam int INV = 64;

  logic          clk_50MHz = 1'b0;
  logic          reset = 1'b1;
  logic          refresh_tick = 1'b0;
  logic [9:0]    x_tank = '0;
  logic [9:0]    y_tank = '0;
  logic [10*NE-1:0] x_bullet_e = '0;
  logic [10*NE-1:0] y_bullet_e = '0;
  logic [NE-1:0] hit;
  logic          tank_detroyed;
  logic [2:0]    boom_frame;
  logic [1:0]    lives;
  logic          respawn;
  logic          game_over;

  int n_vec = 0;
  int n_err = 0;

  // model: phase 0 alive, 1 exploding, 2 guard, 3 game over
  int          m_phase, m_frame, m_lives, m_guard_left;
  logic [NE-1:0] m_hit;
  bit          m_dest, m_resp, m_go;

  tank_damage dut (
    .clk_50MHz     (clk_50MHz),
    .reset         (reset),
    .refresh_tick  (refresh_tick),
    .x_tank        (x_tank),
    .y_tank        (y_tank),
    .x_bullet_e    (x_bullet_e),
    .y_bullet_e    (y_bullet_e),
    .hit           (hit),
    .tank_detroyed (tank_detroyed),
    .boom_frame    (boom_frame),
    .lives         (lives),
    .respawn       (respawn),
    .game_over     (game_over)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NE-1:0] model_overlap();
    logic [NE-1:0] v;
    int xt, yt, xb, yb;
    v = '0;
    xt = int'(x_tank);
    yt = int'(y_tank);
    for (int i = 0; i < NE; i++) begin
      xb = int'(x_bullet_e[10*i +: 10]);
      yb = int'(y_bullet_e[10*i +: 10]);
      v[i] = (xb < xt + 32) && (xb + 4 > xt) && (yb < yt + 32) && (yb + 4 > yt);
    end
    return v;
  endfunction

  function automatic void model_update(input bit rst, input bit tick, input logic [NE-1:0] ov);
    if (rst) begin
      m_phase = 0; m_frame = 0; m_lives = LV; m_guard_left = 0;
      m_hit = '0; m_dest = 0; m_resp = 0; m_go = 0;
      return;
    end
    m_resp = 0;
    if (!tick) return;
    case (m_phase)
      0: begin
        m_hit = ov;
        if (ov != 0) begin
          m_phase = 1; m_lives--; m_frame = 0; m_dest = 1;
        end
      end
      1: begin
        m_hit = '0;
        if (m_frame == BF - 1) begin
          if (m_lives == 0) begin
            m_phase = 3; m_go = 1;
          end else begin
            m_resp = 1; m_frame = 0; m_dest = 0;
`ifdef TANK_INVULN_EN
            m_phase = 2; m_guard_left = INV;
`else
            m_phase = 0;
`endif
          end
        end else begin
          m_frame++;
        end
      end
      2: begin
        m_hit = ov;
        m_guard_left--;
        if (m_guard_left == 0) m_phase = 0;
      end
      default: m_hit = '0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit tick);
    logic [NE-1:0] ov;
    reset = rst;
    refresh_tick = tick;
    ov = model_overlap();
    @(posedge clk_50MHz);
    model_update(rst, tick, ov);
    #1;
    reset = 1'b0;
    refresh_tick = 1'b0;
    chk("hit",   32'(hit),           32'(m_hit));
    chk("dest",  32'(tank_detroyed), 32'(m_dest));
    chk("frame", 32'(boom_frame),    32'(m_frame));
    chk("lives", 32'(lives),         32'(m_lives));
    chk("resp",  32'(respawn),       32'(m_resp));
    chk("gover", 32'(game_over),     32'(m_go));
  endtask

  task automatic set_b(input int i, input int xb, input int yb);
    x_bullet_e[10*i +: 10] = 10'(xb);
    y_bullet_e[10*i +: 10] = 10'(yb);
  endtask

  task automatic clear_bullets();
    set_b(0, 0, 0);
    set_b(1, 100, 100);
    set_b(2, 600, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 1);
  endtask

  task automatic rand_bullets();
    int xb, yb;
    for (int i = 0; i < NE; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        xb = $urandom_range(0, 639);
        yb = $urandom_range(0, 479);
      end else begin
        xb = int'(x_tank) + int'($urandom_range(0, 44)) - 8;
        yb = int'(y_tank) + int'($urandom_range(0, 44)) - 8;
        if (xb < 0) xb = 0;
        if (yb < 0) yb = 0;
        if (xb > 1023) xb = 1023;
        if (yb > 1023) yb = 1023;
      end
      set_b(i, xb, yb);
    end
  endtask

  initial begin
    model_update(1, 0, '0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    chk("rst_lives", 32'(lives), 32'(LV));
    chk("rst_hit", 32'(hit), 32'(0));

    // box edge: x 332 just misses, 331 just touches
    x_tank = 10'd300; y_tank = 10'd400;
    clear_bullets();
    set_b(1, 332, 410);
    step(0, 1);
    chk("edge_miss", 32'(hit), 32'(0));
    set_b(1, 331, 410);
    step(0, 1);
    chk("edge_hit", 32'(hit), 32'(3'b010));
    chk("edge_lives", 32'(lives), 32'(2));

    // reset on the 4th explosion tick wins over the tick
    clear_bullets();
    ticks(3);
    step(1, 1);
    chk("rstb_hit",   32'(hit),           32'(0));
    chk("rstb_dest",  32'(tank_detroyed), 32'(0));
    chk("rstb_frame", 32'(boom_frame),    32'(0));
    chk("rstb_lives", 32'(lives),         32'(LV));
    chk("rstb_go",    32'(game_over),     32'(0));

    // basic hit from the ALIVE state after reset
    set_b(1, 310, 410);
    step(0, 1);
    chk("h1_hit",   32'(hit),           32'(3'b010));
    chk("h1_dest",  32'(tank_detroyed), 32'(1));
    chk("h1_lives", 32'(lives),         32'(2));
    chk("h1_frame", 32'(boom_frame),    32'(0));
    step(0, 0);
    chk("h1_hold", 32'(hit), 32'(3'b010));
    step(0, 1);
    chk("h1_drop", 32'(hit), 32'(0));
    chk("h1_f1", 32'(boom_frame), 32'(1));
    ticks(6);
    chk("h1_f7", 32'(boom_frame), 32'(7));
    chk("h1_dest7", 32'(tank_detroyed), 32'(1));
    clear_bullets();
    step(0, 1);
    chk("rsp_pulse", 32'(respawn), 32'(1));
    chk("rsp_dest", 32'(tank_detroyed), 32'(0));
    step(0, 0);
    chk("rsp_once", 32'(respawn), 32'(0));

`ifdef TANK_INVULN_EN
    ticks(9);
    set_b(1, 310, 410);
    step(0, 1);
    chk("grd_hit", 32'(hit), 32'(3'b010));
    chk("grd_lives", 32'(lives), 32'(2));
    chk("grd_dest", 32'(tank_detroyed), 32'(0));
    clear_bullets();
    ticks(54);
    set_b(1, 310, 410);
    step(0, 1);
    chk("grd_end_dest", 32'(tank_detroyed), 32'(1));
    chk("grd_end_lives", 32'(lives), 32'(1));
    clear_bullets();
    ticks(8);
`else
    // two bullets on one tick cost a single life
    set_b(0, 300, 400);
    set_b(2, 329, 429);
    step(0, 1);
    chk("dbl_hit", 32'(hit), 32'(3'b101));
    chk("dbl_lives", 32'(lives), 32'(1));
    clear_bullets();
    ticks(8);
`endif
    set_b(1, 310, 410);
    step(0, 1);
    chk("last_lives", 32'(lives), 32'(0));
    clear_bullets();
    ticks(8);
    chk("go_flag",  32'(game_over),     32'(1));
    chk("go_dest",  32'(tank_detroyed), 32'(1));
    chk("go_frame", 32'(boom_frame),    32'(BF - 1));
    chk("go_lives", 32'(lives),         32'(0));
    set_b(0, 300, 400);
    ticks(2);
    chk("go_nohit", 32'(hit), 32'(0));
    chk("go_resp", 32'(respawn), 32'(0));

    // randomized traffic
    step(1, 0);
    for (int c = 0; c < 4000; c++) begin
      if (c % 97 == 0) begin
        x_tank = 10'($urandom_range(0, 639));
        y_tank = 10'($urandom_range(0, 479));
      end
      rand_bullets();
      if (m_phase == 3 && $urandom_range(0, 19) == 0)
        step(1, $urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 499) == 0)
        step(1, 1);
      else
        step(0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
